// File: rtl/game_pkg.sv
// Shared definitions for the LED/button memory game.
// Holds the sequencer state encoding and the pattern LFSR constants.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_GEN        = 3'd1,
        S_SHOW_ON    = 3'd2,
        S_SHOW_OFF   = 3'd3,
        S_WAIT_INPUT = 3'd4,
        S_WIN        = 3'd5,
        S_LOSE       = 3'd6
    } state_t;

    localparam int                LFSR_W    = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/game_lfsr.sv
// Free-running Fibonacci LFSR, reloaded with i_seed on reset.
// Only the low OUT_W state bits are exported.
module game_lfsr
    import game_pkg::*;
#(
    parameter int             W     = LFSR_W,
    parameter logic [W-1:0]   TAPS  = LFSR_TAPS,
    parameter int             OUT_W = W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [W-1:0]     i_seed,
    output logic [OUT_W-1:0] o_q
);

    logic [W-1:0] r_q;
    logic         w_fb;

    assign w_fb = ^(r_q & TAPS);
    assign o_q  = r_q[OUT_W-1:0];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_q <= i_seed;
        end else begin
            r_q <= {r_q[W-2:0], w_fb};
        end
    end

endmodule

// File: rtl/game_round_controller.sv
// Memory-game sequencer: grows a random pattern, plays it on the LEDs,
// then checks the player's presses. All outputs are registered from state.
module game_round_controller
    import game_pkg::*;
#(
    parameter int WIDTH         = 3,
    parameter int MAX_LEN       = 8,
    parameter int SHOW_TICKS    = 4,
    parameter int GAP_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 32
) (
    input  logic                         osc_clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [WIDTH:0]               button,
    output logic [WIDTH:0]               led,
    output logic [$clog2(MAX_LEN+1)-1:0] level,
    output logic [$clog2(MAX_LEN+1)-1:0] qtd_digitos_corretos,
    output logic                         busy,
    output logic                         win,
    output logic                         lose
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int BW = (WIDTH > 0) ? $clog2(WIDTH + 1) : 1;
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(max3(SHOW_TICKS, GAP_TICKS, TIMEOUT_TICKS) + 1);

    localparam logic [LW-1:0]  L_ONE  = LW'(1);
    localparam logic [LW-1:0]  L_MAX  = LW'(MAX_LEN);
    localparam logic [TW-1:0]  T_ONE  = TW'(1);
    localparam logic [TW-1:0]  T_SHOW = TW'(SHOW_TICKS - 1);
    localparam logic [TW-1:0]  T_GAP  = TW'(GAP_TICKS - 1);
    localparam logic [TW-1:0]  T_TO   = TW'(TIMEOUT_TICKS - 1);
    localparam logic [WIDTH:0] B_ONE  = (WIDTH+1)'(1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [LW-1:0] r_level;
    logic [LW-1:0] w_level_nxt;
    logic [LW-1:0] r_ok;
    logic [LW-1:0] w_ok_nxt;
    logic [LW-1:0] r_idx;
    logic [LW-1:0] w_idx_nxt;
    logic [TW-1:0] r_tick;
    logic [TW-1:0] w_tick_nxt;
    logic [WIDTH:0] r_btn_q;
    logic [BW-1:0]  r_pat [MAX_LEN];
    logic           w_pat_we;
    logic [BW-1:0]  w_digit;
    logic [WIDTH:0] w_exp_led;
    logic [WIDTH:0] w_led;
    logic           w_press;
    logic           w_hit;

    logic [WIDTH:0] r_led;
    logic [LW-1:0]  r_level_o;
    logic [LW-1:0]  r_ok_o;
    logic           r_busy;
    logic           r_win;
    logic           r_lose;

    game_lfsr #(
        .W     (LFSR_W),
        .TAPS  (LFSR_TAPS),
        .OUT_W (BW)
    ) u_lfsr (
        .i_clk   (osc_clk),
        .i_rst_n (reset_n),
        .i_seed  (LFSR_SEED),
        .o_q     (w_digit)
    );

    assign w_exp_led = B_ONE << r_pat[r_idx[IW-1:0]];
    assign w_press   = |(button & ~r_btn_q);
    // Expected LED is one-hot, so equality also rejects multi-presses
    assign w_hit     = (button == w_exp_led);

    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_ok_nxt    = r_ok;
        w_idx_nxt   = r_idx;
        w_tick_nxt  = r_tick;
        w_pat_we    = 1'b0;
        unique case (r_state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    w_level_nxt = '0;
                    w_ok_nxt    = '0;
                    w_state_nxt = S_GEN;
                end
            end
            S_GEN: begin
                w_pat_we    = 1'b1;
                w_level_nxt = r_level + L_ONE;
                w_idx_nxt   = '0;
                w_tick_nxt  = '0;
                w_state_nxt = S_SHOW_ON;
            end
            S_SHOW_ON: begin
                if (r_tick == T_SHOW) begin
                    w_tick_nxt  = '0;
                    w_state_nxt = S_SHOW_OFF;
                end else begin
                    w_tick_nxt = r_tick + T_ONE;
                end
            end
            S_SHOW_OFF: begin
                if (r_tick == T_GAP) begin
                    w_tick_nxt = '0;
                    if (r_idx + L_ONE < r_level) begin
                        w_idx_nxt   = r_idx + L_ONE;
                        w_state_nxt = S_SHOW_ON;
                    end else begin
                        w_idx_nxt   = '0;
                        w_ok_nxt    = '0;
                        w_state_nxt = S_WAIT_INPUT;
                    end
                end else begin
                    w_tick_nxt = r_tick + T_ONE;
                end
            end
            S_WAIT_INPUT: begin
                if (w_press) begin
                    if (w_hit) begin
                        w_ok_nxt   = r_ok + L_ONE;
                        w_idx_nxt  = r_idx + L_ONE;
                        w_tick_nxt = '0;
                        if (r_idx + L_ONE == r_level) begin
                            w_state_nxt = (r_level == L_MAX) ? S_WIN : S_GEN;
                        end
                    end else begin
                        w_state_nxt = S_LOSE;
                    end
                end else if (r_tick == T_TO) begin
                    w_state_nxt = S_LOSE;
                end else begin
                    w_tick_nxt = r_tick + T_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_led = '0;
        unique case (r_state)
            S_SHOW_ON:    w_led = w_exp_led;
            S_WAIT_INPUT: w_led = button;
            S_WIN:        w_led = '1;
            default:      w_led = '0;
        endcase
    end

    always_ff @(posedge osc_clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_level <= '0;
            r_ok    <= '0;
            r_idx   <= '0;
            r_tick  <= '0;
            r_btn_q <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            r_ok    <= w_ok_nxt;
            r_idx   <= w_idx_nxt;
            r_tick  <= w_tick_nxt;
            r_btn_q <= button;
        end
    end

    always_ff @(posedge osc_clk) begin
        if (w_pat_we) begin
            r_pat[r_level[IW-1:0]] <= w_digit;
        end
    end

    always_ff @(posedge osc_clk) begin
        if (!reset_n) begin
            r_led     <= '0;
            r_level_o <= '0;
            r_ok_o    <= '0;
            r_busy    <= 1'b0;
            r_win     <= 1'b0;
            r_lose    <= 1'b0;
        end else begin
            r_led     <= w_led;
            r_level_o <= r_level;
            r_ok_o    <= r_ok;
            r_busy    <= !(r_state inside {S_IDLE, S_WIN, S_LOSE});
            r_win     <= (r_state == S_WIN);
            r_lose    <= (r_state == S_LOSE);
        end
    end

    assign led                  = r_led;
    assign level                = r_level_o;
    assign qtd_digitos_corretos = r_ok_o;
    assign busy                 = r_busy;
    assign win                  = r_win;
    assign lose                 = r_lose;

endmodule

// File: tb/tb_game_round_controller.sv
// Scoreboard bench for game_round_controller: stimulus queues
// cycle-stamped expectations, a negedge monitor pops and compares them.
module tb_game_round_controller;

    localparam int WIDTH   = 3;
    localparam int MAX_LEN = 4;
    localparam int LW      = $clog2(MAX_LEN + 1);

    localparam int F_LED   = 0;
    localparam int F_LEVEL = 1;
    localparam int F_QTD   = 2;
    localparam int F_BUSY  = 3;
    localparam int F_WIN   = 4;
    localparam int F_LOSE  = 5;

    logic           osc_clk = 1'b0;
    logic           reset_n;
    logic           start;
    logic [WIDTH:0] button;
    logic [WIDTH:0] led;
    logic [LW-1:0]  level;
    logic [LW-1:0]  qtd;
    logic           busy;
    logic           win;
    logic           lose;

    typedef struct {
        int         cyc;
        int         sel;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   pat[MAX_LEN];
    int   pat0_ref;
    int   g;

    game_round_controller #(
        .WIDTH         (WIDTH),
        .MAX_LEN       (MAX_LEN),
        .SHOW_TICKS    (4),
        .GAP_TICKS     (2),
        .TIMEOUT_TICKS (20)
    ) dut (
        .osc_clk              (osc_clk),
        .reset_n              (reset_n),
        .start                (start),
        .button               (button),
        .led                  (led),
        .level                (level),
        .qtd_digitos_corretos (qtd),
        .busy                 (busy),
        .win                  (win),
        .lose                 (lose)
    );

    always #5 osc_clk = ~osc_clk;

    always @(posedge osc_clk) cyc <= cyc + 1;

    function automatic logic [7:0] field(input int sel);
        case (sel)
            F_LED:   return {4'b0, led};
            F_LEVEL: return {5'b0, level};
            F_QTD:   return {5'b0, qtd};
            F_BUSY:  return {7'b0, busy};
            F_WIN:   return {7'b0, win};
            default: return {7'b0, lose};
        endcase
    endfunction

    function automatic string fname(input int sel);
        case (sel)
            F_LED:   return "led";
            F_LEVEL: return "level";
            F_QTD:   return "qtd";
            F_BUSY:  return "busy";
            F_WIN:   return "win";
            default: return "lose";
        endcase
    endfunction

    function automatic logic [3:0] oh(input int d);
        logic [3:0] one;
        one = 4'b0001;
        return one << d;
    endfunction

    function automatic int idx_of(input logic [3:0] v);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Monitor: compare every expectation stamped with the current cycle
    always @(negedge osc_clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_chk++;
            if (e.cyc == cyc && field(e.sel) === e.val) n_pass++;
            else $display("FAIL %s @cyc %0d: got %0h want %0h (now %0d)",
                          fname(e.sel), e.cyc, field(e.sel), e.val, cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time budget exceeded at cyc %0d", cyc);
        $fatal(1);
    end

    task automatic tick();
        @(posedge osc_clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic expect_at(input int c, input int sel, input logic [7:0] v);
        sb.push_back('{c, sel, v});
    endtask

    task automatic check_bit(input string tag, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0b want %0b", tag, cyc, act, exp);
    endtask

    task automatic expect_zero(input int c);
        expect_at(c, F_LED, 0);
        expect_at(c, F_LEVEL, 0);
        expect_at(c, F_QTD, 0);
        expect_at(c, F_BUSY, 0);
        expect_at(c, F_WIN, 0);
        expect_at(c, F_LOSE, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        button  = '0;
        expect_zero(cyc + 1);
        tick();
        tick();
        reset_n = 1'b1;
        expect_zero(cyc + 1);
        expect_zero(cyc + 10);
        repeat (10) tick();
    endtask

    task automatic start_game(output int gs);
        int k;
        start = 1'b1;
        k = cyc + 1;
        expect_at(k + 1, F_LEVEL, 0);
        expect_at(k + 1, F_BUSY, 1);
        expect_at(k + 1, F_WIN, 0);
        expect_at(k + 1, F_LOSE, 0);
        tick();
        start = 1'b0;
        gs = k;
    endtask

    // mode: 0 all correct, 1 wrong digit at fd, 2 double press at fd,
    // 3 timeout, 4 stop mid-playback
    task automatic run_round(input int gr, input int L, input int mode,
                             input int fd, output int g_next);
        int         w;
        int         p;
        logic [3:0] b;
        logic [3:0] lv;
        bit         stop;
        g_next = 0;
        stop   = 0;
        expect_at(gr + 2, F_LEVEL, 8'(L));
        expect_at(gr + 2, F_BUSY, 1);
        if (mode == 4) begin
            wait_cyc(gr + 4);
        end else begin
            for (int d = 0; d < L - 1; d++) begin
                expect_at(gr + 2 + 6*d, F_LED, {4'b0, oh(pat[d])});
                expect_at(gr + 5 + 6*d, F_LED, {4'b0, oh(pat[d])});
                expect_at(gr + 6 + 6*d, F_LED, 0);
            end
            wait_cyc(gr + 2 + 6*(L-1));
            lv = led;
            check_bit("new_digit_onehot", $onehot(lv), 1'b1);
            pat[L-1] = idx_of(lv);
            expect_at(gr + 5 + 6*(L-1), F_LED, {4'b0, oh(pat[L-1])});
            expect_at(gr + 6 + 6*(L-1), F_LED, 0);
            expect_at(gr + 7 + 6*(L-1), F_LED, 0);
            w = gr + 1 + 6*L;
            wait_cyc(w);
            if (mode == 3) begin
                expect_at(w + 1, F_QTD, 0);
                expect_at(w + 20, F_LOSE, 0);
                expect_at(w + 21, F_LOSE, 1);
                expect_at(w + 21, F_BUSY, 0);
                expect_at(w + 21, F_LED, 0);
                wait_cyc(w + 21);
            end else begin
                for (int d = 0; d < L && !stop; d++) begin
                    p = cyc + 1;
                    if (mode == 1 && d == fd) b = oh((pat[d] + 1) % 4);
                    else if (mode == 2 && d == fd) b = 4'b0011;
                    else b = oh(pat[d]);
                    button = b;
                    expect_at(p, F_LED, {4'b0, b});
                    if ((mode == 1 || mode == 2) && d == fd) begin
                        expect_at(p + 1, F_LOSE, 1);
                        expect_at(p + 1, F_QTD, 8'(fd));
                        expect_at(p + 1, F_LED, 0);
                        expect_at(p + 1, F_LEVEL, 8'(L));
                        expect_at(p + 1, F_BUSY, 0);
                        tick();
                        button = '0;
                        wait_cyc(p + 1);
                        stop = 1;
                    end else begin
                        expect_at(p + 1, F_QTD, 8'(d + 1));
                        if (d == L - 1 && L == MAX_LEN) begin
                            expect_at(p + 1, F_WIN, 1);
                            expect_at(p + 1, F_LED, 8'h0F);
                            expect_at(p + 1, F_BUSY, 0);
                            expect_at(p + 1, F_LEVEL, 8'(L));
                        end
                        tick();
                        button = '0;
                        if (d == L - 1) g_next = p;
                        else tick();
                    end
                end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        button  = '0;
        do_reset();

        start_game(g);
        for (int L = 1; L <= MAX_LEN; L++) run_round(g, L, 0, 0, g);
        pat0_ref = pat[0];
        repeat (3) tick();

        start_game(g);
        run_round(g, 1, 0, 0, g);
        run_round(g, 2, 1, 1, g);
        repeat (3) tick();

        start_game(g);
        run_round(g, 1, 2, 0, g);
        repeat (2) tick();

        start_game(g);
        run_round(g, 1, 3, 0, g);

        start_game(g);
        run_round(g, 1, 0, 0, g);
        run_round(g, 2, 0, 0, g);
        run_round(g, 3, 4, 0, g);

        do_reset();
        start_game(g);
        expect_at(g + 2, F_LEVEL, 1);
        expect_at(g + 2, F_LED, {4'b0, oh(pat0_ref)});
        wait_cyc(g + 4);
        tick();

        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
